// File: rtl/fetch_if.sv
// Bundle between the fetch stage, the instruction memory, the hazard/redirect
// logic and the decode stage. The master side is the fetch stage itself.
interface fetch_if #(
  parameter int CNT_W = 16
);
  logic             stall;
  logic             redirect;
  logic [9:0]       redirect_target;
  logic [31:0]      instruction;
  logic [9:0]       read_address;
  logic [31:0]      ifid_instruction;
  logic [9:0]       ifid_pc;
  logic [9:0]       ifid_pc_plus4;
  logic             ifid_valid;
  logic             halted;
  logic             misaligned;
  logic [CNT_W-1:0] fetch_count;

  modport master (
    input  stall, redirect, redirect_target, instruction,
    output read_address, ifid_instruction, ifid_pc, ifid_pc_plus4,
           ifid_valid, halted, misaligned, fetch_count
  );

  modport slave (
    output stall, redirect, redirect_target, instruction,
    input  read_address, ifid_instruction, ifid_pc, ifid_pc_plus4,
           ifid_valid, halted, misaligned, fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the instruction memory and
// fills the IF/ID register, with stall, redirect/flush, start bubble and halt.
module fetch_stage #(
  parameter logic [9:0] RESET_PC    = 10'd0,
  parameter logic [5:0] HALT_OPCODE = 6'b111111,
  parameter int         CNT_W       = 16
) (
  input  logic  clk,
  input  logic  reset,
  fetch_if.master bus
);

  typedef enum logic [1:0] {
    ST_START,
    ST_RUN,
    ST_HALT
  } state_t;

  state_t           state_reg;
  logic [9:0]       pc_reg;
  logic [31:0]      ifid_instr_reg;
  logic [9:0]       ifid_pc_reg;
  logic [9:0]       ifid_pc_plus4_reg;
  logic             ifid_valid_reg;
  logic             halted_reg;
  logic             misaligned_reg;
  logic [CNT_W-1:0] count_reg;

  // The memory samples the address on negedge, so the PC goes out unregistered.
  assign bus.read_address     = pc_reg;
  assign bus.ifid_instruction = ifid_instr_reg;
  assign bus.ifid_pc          = ifid_pc_reg;
  assign bus.ifid_pc_plus4    = ifid_pc_plus4_reg;
  assign bus.ifid_valid       = ifid_valid_reg;
  assign bus.halted           = halted_reg;
  assign bus.misaligned       = misaligned_reg;
  assign bus.fetch_count      = count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg         <= ST_START;
      pc_reg            <= RESET_PC;
      ifid_instr_reg    <= '0;
      ifid_pc_reg       <= '0;
      ifid_pc_plus4_reg <= '0;
      ifid_valid_reg    <= 1'b0;
      halted_reg        <= 1'b0;
      misaligned_reg    <= 1'b0;
      count_reg         <= '0;
    end else begin
      case (state_reg)
        ST_START: begin
          state_reg <= ST_RUN;
        end
        ST_RUN: begin
          if (bus.redirect) begin
            pc_reg            <= {bus.redirect_target[9:2], 2'b00};
            ifid_instr_reg    <= '0;
            ifid_pc_reg       <= '0;
            ifid_pc_plus4_reg <= '0;
            ifid_valid_reg    <= 1'b0;
            if (bus.redirect_target[1:0] != 2'b00) begin
              misaligned_reg <= 1'b1;
            end
          end else if (!bus.stall) begin
            ifid_instr_reg    <= bus.instruction;
            ifid_pc_reg       <= pc_reg;
            ifid_pc_plus4_reg <= pc_reg + 10'd4;
            ifid_valid_reg    <= 1'b1;
            if (count_reg != {CNT_W{1'b1}}) begin
              count_reg <= count_reg + 1'b1;
            end
            // The halt word itself is delivered; only the PC advance stops.
            if (bus.instruction[31:26] == HALT_OPCODE) begin
              state_reg  <= ST_HALT;
              halted_reg <= 1'b1;
            end else begin
              pc_reg <= pc_reg + 10'd4;
            end
          end
        end
        ST_HALT: begin
          halted_reg        <= 1'b1;
          ifid_instr_reg    <= '0;
          ifid_pc_reg       <= '0;
          ifid_pc_plus4_reg <= '0;
          ifid_valid_reg    <= 1'b0;
        end
        default: begin
          state_reg <= ST_START;
        end
      endcase
    end
  end

endmodule
